alu_issue_stage: RTL and testbench

Registered issue and retire stage placed directly in front of the 8-bit combinational ALU. It accepts {opcode, A, B} commands over a valid/ready interface and buffers them in a small FIFO. It launches one command at a time into the ALU, captures the ALU outputs one cycle later, and presents them on a valid/ready response interface. Illegal opcodes are rejected locally and never reach the ALU.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_cmd_fifo.sv | 48 ++++
 rtl/alu_issue_stage.sv | 163 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue/retire stage and its command FIFO.
package alu_pkg;

  localparam int ALU_W = 8;
  localparam int RES_W = 16;
  localparam int SEL_W = 4;
  localparam int CMD_W = SEL_W + 2 * ALU_W;

  localparam logic [SEL_W-1:0] OP_ADD = 4'b0000;
  localparam logic [SEL_W-1:0] OP_SUB = 4'b0001;
  localparam logic [SEL_W-1:0] OP_MUL = 4'b0010;
  localparam logic [SEL_W-1:0] OP_DIV = 4'b0011;
  localparam logic [SEL_W-1:0] OP_SHL = 4'b0100;
  localparam logic [SEL_W-1:0] OP_SHR = 4'b0101;
  localparam logic [SEL_W-1:0] OP_AND = 4'b1000;
  localparam logic [SEL_W-1:0] OP_OR  = 4'b1001;
  localparam logic [SEL_W-1:0] OP_XOR = 4'b1010;
  localparam logic [SEL_W-1:0] OP_GT  = 4'b1110;
  localparam logic [SEL_W-1:0] OP_EQ  = 4'b1111;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  function automatic logic is_legal_op(input logic [SEL_W-1:0] sel);
    case (sel)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SHL, OP_SHR,
      OP_AND, OP_OR, OP_XOR, OP_GT, OP_EQ: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit so full/empty fall out of the difference.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [CMD_W-1:0] wdata_i,
  input  logic             pop_i,
  output logic [CMD_W-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;

  assign wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is data only; emptiness after reset comes from the pointers.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count_o == CNT_W'(DEPTH));
  assign empty_o = (count_o == '0);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/retire stage in front of the combinational 8-bit ALU: queue commands, launch one at a time,
// capture the ALU one cycle later and hold it on a valid/ready response port.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_sel,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [15:0]      alu_result,
  input  logic [7:0]       alu_quotient,
  input  logic [7:0]       alu_remainder,
  input  logic             alu_carry,
  input  logic             alu_div0,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_result,
  output logic [7:0]       rsp_quotient,
  output logic [7:0]       rsp_remainder,
  output logic             rsp_carry,
  output logic             rsp_div0,
  output logic [3:0]       rsp_sel,
  output logic             rsp_illegal,
  output logic [CNT_W-1:0] fifo_count
);

  state_e             state_q, state_d;
  logic [ALU_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [SEL_W-1:0]   alu_sel_q, alu_sel_d;
  logic [RES_W-1:0]   rsp_result_q, rsp_result_d;
  logic [ALU_W-1:0]   rsp_quot_q, rsp_quot_d, rsp_rem_q, rsp_rem_d;
  logic               rsp_carry_q, rsp_carry_d, rsp_div0_q, rsp_div0_d;
  logic [SEL_W-1:0]   rsp_sel_q, rsp_sel_d;
  logic               rsp_ill_q, rsp_ill_d;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty, pop_slot;
  logic [CMD_W-1:0]   fifo_rdata;
  logic [SEL_W-1:0]   head_sel;
  logic [ALU_W-1:0]   head_a, head_b;

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  assign {head_sel, head_a, head_b} = fifo_rdata;

  alu_cmd_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i ({cmd_sel, cmd_a, cmd_b}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_result_d = rsp_result_q;
    rsp_quot_d   = rsp_quot_q;
    rsp_rem_d    = rsp_rem_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_div0_d   = rsp_div0_q;
    rsp_sel_d    = rsp_sel_q;
    rsp_ill_d    = rsp_ill_q;
    pop_slot     = 1'b0;
    fifo_pop     = 1'b0;

    case (state_q)
      IDLE: pop_slot = 1'b1;
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_quot_d   = alu_quotient;
        rsp_rem_d    = alu_remainder;
        rsp_carry_d  = alu_carry;
        rsp_div0_d   = alu_div0;
        rsp_sel_d    = alu_sel_q;
        rsp_ill_d    = 1'b0;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          pop_slot = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Illegal opcodes bypass the ALU and answer directly; alu_* keep their last legal launch.
    if (pop_slot && !fifo_empty) begin
      fifo_pop = 1'b1;
      if (is_legal_op(head_sel)) begin
        alu_a_d   = head_a;
        alu_b_d   = head_b;
        alu_sel_d = head_sel;
        state_d   = EXEC;
      end else begin
        rsp_result_d = '0;
        rsp_quot_d   = '0;
        rsp_rem_d    = '0;
        rsp_carry_d  = 1'b0;
        rsp_div0_d   = 1'b0;
        rsp_sel_d    = head_sel;
        rsp_ill_d    = 1'b1;
        state_d      = RESP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rsp_result_q <= '0;
      rsp_quot_q   <= '0;
      rsp_rem_q    <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_div0_q   <= 1'b0;
      rsp_sel_q    <= '0;
      rsp_ill_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_result_q <= rsp_result_d;
      rsp_quot_q   <= rsp_quot_d;
      rsp_rem_q    <= rsp_rem_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_div0_q   <= rsp_div0_d;
      rsp_sel_q    <= rsp_sel_d;
      rsp_ill_q    <= rsp_ill_d;
    end
  end

  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_sel       = alu_sel_q;
  assign rsp_valid     = (state_q == RESP);
  assign rsp_result    = rsp_result_q;
  assign rsp_quotient  = rsp_quot_q;
  assign rsp_remainder = rsp_rem_q;
  assign rsp_carry     = rsp_carry_q;
  assign rsp_div0      = rsp_div0_q;
  assign rsp_sel       = rsp_sel_q;
  assign rsp_illegal   = rsp_ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a behavioural ALU drives the DUT's ALU port, and a queue of expected
// responses (computed from the command alone) is compared at every response handshake.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [15:0] result;
    logic [7:0]  quo;
    logic [7:0]  rem;
    logic        carry;
    logic        div0;
    logic [3:0]  sel;
    logic        ill;
  } rsp_t;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [3:0]  cmd_sel, alu_sel, rsp_sel;
  logic [7:0]  cmd_a, cmd_b, alu_a, alu_b;
  logic [15:0] alu_result, rsp_result;
  logic [7:0]  alu_quotient, alu_remainder, rsp_quotient, rsp_remainder;
  logic        alu_carry, alu_div0, rsp_carry, rsp_div0, rsp_illegal;
  logic [2:0]  fifo_count;
  logic [31:0] noise;

  int   checks = 0;
  int   failures = 0;
  rsp_t exp_q[$];

  // Reference behaviour of one command: an ALU answer for legal opcodes, zeros + illegal flag otherwise.
  function automatic rsp_t model(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
    rsp_t o;
    int unsigned ua, ub;
    ua = a;
    ub = b;
    o = '0;
    o.sel = s;
    case (s)
      4'h0: begin o.result = 16'(ua + ub); o.carry = (ua + ub) > 255; end
      4'h1: begin o.result = 16'((ua - ub) & 255); o.carry = (ua < ub); end
      4'h2: o.result = 16'(ua * ub);
      4'h3: if (ub == 0) o.div0 = 1'b1;
            else begin o.quo = 8'(ua / ub); o.rem = 8'(ua % ub); end
      4'h4: o.result = 16'(ua << (ub % 8));
      4'h5: o.result = 16'(ua >> (ub % 8));
      4'h8: o.result = 16'(ua & ub);
      4'h9: o.result = 16'(ua | ub);
      4'hA: o.result = 16'(ua ^ ub);
      4'hE: o.result = (ua > ub) ? 16'd1 : 16'd0;
      4'hF: o.result = (ua == ub) ? 16'd1 : 16'd0;
      default: o.ill = 1'b1;
    endcase
    return o;
  endfunction

  rsp_t env;
  assign env           = model(alu_sel, alu_a, alu_b);
  assign alu_result    = env.result ^ noise[15:0];
  assign alu_quotient  = env.quo ^ noise[23:16];
  assign alu_remainder = env.rem ^ noise[31:24];
  assign alu_carry     = env.carry ^ noise[0];
  assign alu_div0      = env.div0 ^ noise[1];

  alu_issue_stage #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_quotient(alu_quotient), .alu_remainder(alu_remainder),
    .alu_carry(alu_carry), .alu_div0(alu_div0),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_carry(rsp_carry),
    .rsp_div0(rsp_div0), .rsp_sel(rsp_sel), .rsp_illegal(rsp_illegal), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, observe handshakes just after, then let the rising edge happen.
  task automatic cycle(input logic v, input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                       input logic rr, output logic vld, output rsp_t snap);
    rsp_t e;
    @(negedge clk);
    cmd_valid = v; cmd_sel = s; cmd_a = a; cmd_b = b; rsp_ready = rr;
    #1;
    vld  = rsp_valid;
    snap = {rsp_result, rsp_quotient, rsp_remainder, rsp_carry, rsp_div0, rsp_sel, rsp_illegal};
    if (rsp_valid && rr) begin
      if (exp_q.size() == 0) begin
        chk("spurious_rsp", 64'(snap), 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        chk("rsp", 64'(snap), 64'(e));
      end
    end
    if (v && cmd_ready) exp_q.push_back(model(s, a, b));
    @(posedge clk);
  endtask

  task automatic drain(output int n);
    logic dv;
    rsp_t ds;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      cycle(1'b0, 4'h0, 8'h0, 8'h0, 1'b1, dv, ds);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic v;
    rsp_t snap, hold;
    int   n;

    noise = '0;
    cmd_valid = 1'b0; cmd_sel = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_rsp_data", 64'({rsp_result, rsp_quotient, rsp_remainder, rsp_carry, rsp_div0, rsp_sel, rsp_illegal}), 64'd0);
    chk("rst_alu", 64'({alu_a, alu_b, alu_sel}), 64'd0);
    rst_n = 1'b1;

    // add 20+15: response appears two edges after the push edge
    cycle(1'b1, 4'h0, 8'd20, 8'd15, 1'b1, v, snap);
    cycle(1'b0, 4'h0, 8'd0, 8'd0, 1'b1, v, snap);
    chk("lat_idle", 64'(v), 64'd0);
    cycle(1'b0, 4'h0, 8'd0, 8'd0, 1'b1, v, snap);
    chk("lat_exec", 64'(v), 64'd0);
    cycle(1'b0, 4'h0, 8'd0, 8'd0, 1'b1, v, snap);
    chk("lat_resp", 64'(v), 64'd1);
    chk("add_result", 64'(snap.result), 64'd35);
    chk("add_carry", 64'(snap.carry), 64'd0);
    chk("add_sel", 64'(snap.sel), 64'd0);
    drain(n);

    // five pushes with the consumer stalled: one in RESP, four queued, FIFO full
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'h0, 8'(10 * i + 1), 8'(i + 3), 1'b0, v, snap);
    @(negedge clk);
    #1;
    chk("full_ready", 64'(cmd_ready), 64'd0);
    chk("full_count", 64'(fifo_count), 64'd4);
    drain(n);
    chk("b2b_cycles", 64'(n), 64'd9);

    // divide by zero, then a normal divide
    cycle(1'b1, 4'h3, 8'd40, 8'd0, 1'b1, v, snap);
    n = 0;
    do begin cycle(1'b0, 4'h0, 8'd0, 8'd0, 1'b1, v, snap); n++; end while (!v && n < 10);
    chk("div0_flag", 64'(snap.div0), 64'd1);
    cycle(1'b1, 4'h3, 8'd40, 8'd5, 1'b1, v, snap);
    n = 0;
    do begin cycle(1'b0, 4'h0, 8'd0, 8'd0, 1'b1, v, snap); n++; end while (!v && n < 10);
    chk("div_q_r_d0", 64'({snap.quo, snap.rem, snap.div0}), 64'({8'd8, 8'd0, 1'b0}));

    // illegal opcode 0110: answered one edge after the pop, alu_* untouched
    cycle(1'b1, 4'h6, 8'd1, 8'd1, 1'b1, v, snap);
    cycle(1'b0, 4'h0, 8'd0, 8'd0, 1'b1, v, snap);
    chk("ill_not_yet", 64'(v), 64'd0);
    cycle(1'b0, 4'h0, 8'd0, 8'd0, 1'b1, v, snap);
    chk("ill_lat", 64'(v), 64'd1);
    chk("ill_rsp", 64'(snap), 64'({16'd0, 8'd0, 8'd0, 1'b0, 1'b0, 4'h6, 1'b1}));
    chk("ill_alu_kept", 64'({alu_a, alu_b, alu_sel}), 64'({8'd40, 8'd5, 4'h3}));
    drain(n);

    // stall with the ALU outputs scrambled: held response must not move
    cycle(1'b1, 4'h2, 8'd100, 8'd200, 1'b0, v, snap);
    n = 0;
    do begin cycle(1'b0, 4'h0, 8'd0, 8'd0, 1'b0, v, snap); n++; end while (!v && n < 10);
    hold = snap;
    chk("stall_mul", 64'(hold.result), 64'd20000);
    for (int i = 0; i < 10; i++) begin
      noise = $urandom | 32'h1;
      cycle(1'b0, 4'h0, 8'd0, 8'd0, 1'b0, v, snap);
      chk("stall_hold", 64'({v, snap}), 64'({1'b1, hold}));
    end
    noise = '0;
    drain(n);

    // reset while in EXEC with three commands queued
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'h1, 8'(50 + i), 8'(7 + i), 1'b0, v, snap);
    cycle(1'b1, 4'h9, 8'd77, 8'd66, 1'b1, v, snap);
    @(negedge clk);
    #1;
    chk("pre_rst_count", 64'(fifo_count), 64'd3);
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 64'({rsp_valid, fifo_count, alu_a, alu_b, alu_sel, cmd_ready}),
        64'({1'b0, 3'd0, 8'd0, 8'd0, 4'd0, 1'b1}));
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 4'h0, 8'd0, 8'd0, 1'b1, v, snap);
      chk("post_rst_quiet", 64'(v), 64'd0);
    end

    // random traffic, including illegal opcodes and consumer back-pressure
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 3) != 0), v, snap);
    end
    drain(n);
    cycle(1'b0, 4'h0, 8'd0, 8'd0, 1'b1, v, snap);
    chk("final_idle", 64'({v, fifo_count}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
